// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: word-serial host controller for the mod_exp core.
// Host writes shift WW-bit words into the NBITS-bit operand registers
// (least significant word first). start fires a one-cycle enable_p to the
// core, and the captured result is popped back out one word per rd_en.
// done and err are sticky until irq_clr.
module mod_exp_ctrl #(
  parameter int NBITS = 2048,
  parameter int WW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [WW-1:0]    wr_data,
  input  logic             start,
  input  logic             rd_en,
  output logic [WW-1:0]    rd_data,
  input  logic             irq_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             enable_p,
  output logic [NBITS-1:0] a,
  output logic [NBITS-1:0] exp,
  output logic [NBITS-1:0] m,
  output logic [11:0]      m_size,
  output logic [NBITS-1:0] r_red,
  input  logic [NBITS-1:0] y,
  input  logic             done_irq_p
);

  // Operands are assumed to span at least two words.
  localparam int NWORDS = NBITS / WW;
  localparam int CW     = $clog2(NWORDS) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic             enable_d, done_d, err_d;
  logic             wr_ok, capture, pop;
  logic [NBITS-1:0] result;
  logic [NBITS-1:0] result_nx;
  logic [CW-1:0]    rd_cnt;

  assign busy      = (state == RUN);
  assign result_nx = result >> WW;

  // Next-state, status-flag and datapath-strobe decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state;
    enable_d = 1'b0;
    done_d   = done;
    err_d    = err;
    wr_ok    = 1'b0;
    capture  = 1'b0;
    pop      = 1'b0;

    // Clears are applied first so any set event below overrides them.
    if (irq_clr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state)
      IDLE, DONE: begin
        wr_ok = wr_en;
        if (wr_en && (wr_sel > 3'd4)) err_d = 1'b1;
        if (start) begin
          state_d  = RUN;
          enable_d = 1'b1;
          done_d   = 1'b0;
        end else if ((state == DONE) && rd_en) begin
          pop = 1'b1;
          if (rd_cnt == LAST_WORD) state_d = IDLE;
        end
      end
      RUN: begin
        // Operands must stay stable while the core works on them.
        if (wr_en || start) err_d = 1'b1;
        if (done_irq_p) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state    <= IDLE;
      enable_p <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      enable_p <= enable_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Operand shift-in, result capture and word-serial unload.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the wide operand/result registers are reset explicitly because
    // their reset contents are visible to the core and the host.
    if (rst) begin
      a       <= '0;
      exp     <= '0;
      m       <= '0;
      r_red   <= '0;
      m_size  <= 12'd2048;
      result  <= '0;
      rd_data <= '0;
      rd_cnt  <= '0;
    end else begin
      if (wr_ok) begin
        case (wr_sel)
          3'd0:    m      <= {wr_data, m[NBITS-1:WW]};
          3'd1:    a      <= {wr_data, a[NBITS-1:WW]};
          3'd2:    exp    <= {wr_data, exp[NBITS-1:WW]};
          3'd3:    r_red  <= {wr_data, r_red[NBITS-1:WW]};
          3'd4:    m_size <= wr_data[11:0];
          default: ;
        endcase
      end
      if (capture) begin
        result  <= y;
        rd_data <= y[WW-1:0];
        rd_cnt  <= '0;
      end else if (pop) begin
        result  <= result_nx;
        rd_data <= result_nx[WW-1:0];
        rd_cnt  <= rd_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: table-driven register-load vectors plus hand-written
// sequences for start/run/unload, reset mid-run, and a full-width
// load/unload against a stub core.
module tb_mod_exp_ctrl;

  localparam int SNB = 64;
  localparam int BNB = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small (64-bit) instance
  logic            s_wr_en, s_start, s_rd_en, s_irq_clr, s_done_irq_p;
  logic [2:0]      s_wr_sel;
  logic [31:0]     s_wr_data, s_rd_data;
  logic            s_busy, s_done, s_err, s_enable_p;
  logic [SNB-1:0]  s_a, s_exp, s_m, s_r_red, s_y;
  logic [11:0]     s_m_size;

  // Full-size instance
  logic            b_wr_en, b_start, b_rd_en, b_irq_clr, b_done_irq_p;
  logic [2:0]      b_wr_sel;
  logic [31:0]     b_wr_data, b_rd_data;
  logic            b_busy, b_done, b_err, b_enable_p;
  logic [BNB-1:0]  b_a, b_exp, b_m, b_r_red, b_y;
  logic [11:0]     b_m_size;

  mod_exp_ctrl #(.NBITS(SNB), .WW(32)) u_small (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_data(s_wr_data),
    .start(s_start), .rd_en(s_rd_en), .rd_data(s_rd_data), .irq_clr(s_irq_clr),
    .busy(s_busy), .done(s_done), .err(s_err), .enable_p(s_enable_p),
    .a(s_a), .exp(s_exp), .m(s_m), .m_size(s_m_size), .r_red(s_r_red),
    .y(s_y), .done_irq_p(s_done_irq_p)
  );

  mod_exp_ctrl #(.NBITS(BNB), .WW(32)) u_big (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
    .start(b_start), .rd_en(b_rd_en), .rd_data(b_rd_data), .irq_clr(b_irq_clr),
    .busy(b_busy), .done(b_done), .err(b_err), .enable_p(b_enable_p),
    .a(b_a), .exp(b_exp), .m(b_m), .m_size(b_m_size), .r_red(b_r_red),
    .y(b_y), .done_irq_p(b_done_irq_p)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] data;
    logic        clr;
    logic [63:0] m, a, e, r;
    logic [11:0] ms;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [BNB-1:0] bm, br, be, by;
    logic [31:0] w;

    // Cumulative expected register contents after each vector (64-bit DUT).
    vecs[0]  = '{1'b1, 3'd0, 32'h89ABCDEF, 1'b0, 64'h89ABCDEF_00000000, 64'h0, 64'h0, 64'h0, 12'd2048, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 32'h01234567, 1'b0, 64'h01234567_89ABCDEF, 64'h0, 64'h0, 64'h0, 12'd2048, 1'b0};
    vecs[2]  = '{1'b1, 3'd4, 32'h00000040, 1'b0, 64'h01234567_89ABCDEF, 64'h0, 64'h0, 64'h0, 12'd64,   1'b0};
    vecs[3]  = '{1'b1, 3'd6, 32'hDEADBEEF, 1'b0, 64'h01234567_89ABCDEF, 64'h0, 64'h0, 64'h0, 12'd64,   1'b1};
    vecs[4]  = '{1'b1, 3'd1, 32'h11111111, 1'b0, 64'h01234567_89ABCDEF, 64'h11111111_00000000, 64'h0, 64'h0, 12'd64, 1'b1};
    vecs[5]  = '{1'b1, 3'd2, 32'h00000003, 1'b0, 64'h01234567_89ABCDEF, 64'h11111111_00000000, 64'h00000003_00000000, 64'h0, 12'd64, 1'b1};
    vecs[6]  = '{1'b1, 3'd3, 32'hAAAA5555, 1'b0, 64'h01234567_89ABCDEF, 64'h11111111_00000000, 64'h00000003_00000000, 64'hAAAA5555_00000000, 12'd64, 1'b1};
    vecs[7]  = '{1'b1, 3'd0, 32'hCAFEF00D, 1'b0, 64'hCAFEF00D_01234567, 64'h11111111_00000000, 64'h00000003_00000000, 64'hAAAA5555_00000000, 12'd64, 1'b1};
    vecs[8]  = '{1'b1, 3'd4, 32'h12345FFF, 1'b0, 64'hCAFEF00D_01234567, 64'h11111111_00000000, 64'h00000003_00000000, 64'hAAAA5555_00000000, 12'hFFF, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 32'h00000000, 1'b1, 64'hCAFEF00D_01234567, 64'h11111111_00000000, 64'h00000003_00000000, 64'hAAAA5555_00000000, 12'hFFF, 1'b0};
    vecs[10] = '{1'b1, 3'd5, 32'h55555555, 1'b1, 64'hCAFEF00D_01234567, 64'h11111111_00000000, 64'h00000003_00000000, 64'hAAAA5555_00000000, 12'hFFF, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 32'h00000000, 1'b1, 64'hCAFEF00D_01234567, 64'h11111111_00000000, 64'h00000003_00000000, 64'hAAAA5555_00000000, 12'hFFF, 1'b0};

    s_wr_en = 0; s_wr_sel = 0; s_wr_data = 0; s_start = 0; s_rd_en = 0;
    s_irq_clr = 0; s_done_irq_p = 0; s_y = '0;
    b_wr_en = 0; b_wr_sel = 0; b_wr_data = 0; b_start = 0; b_rd_en = 0;
    b_irq_clr = 0; b_done_irq_p = 0; b_y = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst busy",     s_busy, 0);
    check("rst done",     s_done, 0);
    check("rst err",      s_err, 0);
    check("rst enable_p", s_enable_p, 0);
    check("rst rd_data",  s_rd_data, 0);
    check("rst m",        s_m, 0);
    check("rst m_size",   s_m_size, 12'd2048);

    // Register load vectors in IDLE
    for (int i = 0; i < 12; i++) begin
      s_wr_en = vecs[i].wr; s_wr_sel = vecs[i].sel; s_wr_data = vecs[i].data;
      s_irq_clr = vecs[i].clr;
      tick();
      s_wr_en = 0; s_irq_clr = 0;
      check($sformatf("v%0d m", i),      s_m,      vecs[i].m);
      check($sformatf("v%0d a", i),      s_a,      vecs[i].a);
      check($sformatf("v%0d exp", i),    s_exp,    vecs[i].e);
      check($sformatf("v%0d r_red", i),  s_r_red,  vecs[i].r);
      check($sformatf("v%0d m_size", i), s_m_size, vecs[i].ms);
      check($sformatf("v%0d err", i),    s_err,    vecs[i].err);
    end

    // Start held 3 cycles: one enable_p pulse, extra starts flag err
    cnt = 0;
    s_start = 1;
    check("start enp same cycle", s_enable_p, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) check("start enp first", s_enable_p, 1);
      cnt += int'(s_enable_p);
    end
    s_start = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(s_enable_p);
    end
    check("start pulse count", cnt, 1);
    check("run busy", s_busy, 1);
    check("run err from start", s_err, 1);

    // Writes during RUN
    s_irq_clr = 1; tick(); s_irq_clr = 0;
    check("run clr err", s_err, 0);
    s_wr_en = 1; s_wr_sel = 3'd1; s_wr_data = 32'hFFFFFFFF; tick(); s_wr_en = 0;
    check("run wr a held", s_a, 64'h11111111_00000000);
    check("run wr err", s_err, 1);
    s_wr_en = 1; s_wr_sel = 3'd0; s_irq_clr = 1; tick(); s_wr_en = 0; s_irq_clr = 0;
    check("run clr+wr err", s_err, 1);
    check("run clr+wr m held", s_m, 64'hCAFEF00D_01234567);
    s_irq_clr = 1; tick(); s_irq_clr = 0;
    check("run clr err 2", s_err, 0);
    check("run still busy", s_busy, 1);

    // Completion (with simultaneous irq_clr, set wins) and unload
    s_y = 64'hFEDCBA98_76543210;
    s_done_irq_p = 1; s_irq_clr = 1; tick(); s_done_irq_p = 0; s_irq_clr = 0;
    check("cmp done", s_done, 1);
    check("cmp busy", s_busy, 0);
    check("cmp rd_data w0", s_rd_data, 32'h76543210);
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("rd w1", s_rd_data, 32'hFEDCBA98);
    check("rd w1 done", s_done, 1);
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("rd last done", s_done, 1);
    check("rd last busy", s_busy, 0);
    check("rd last data", s_rd_data, 0);
    s_irq_clr = 1; tick(); s_irq_clr = 0;
    check("clr done", s_done, 0);
    s_done_irq_p = 1; tick(); s_done_irq_p = 0;
    check("idle irq ignored", s_done, 0);

    // Simultaneous write and start: write lands, pulse next cycle
    s_wr_en = 1; s_wr_sel = 3'd2; s_wr_data = 32'h00000007; s_start = 1;
    tick();
    s_wr_en = 0; s_start = 0;
    check("wr+start exp", s_exp, 64'h00000007_00000003);
    check("wr+start enp", s_enable_p, 1);
    check("wr+start busy", s_busy, 1);
    tick();
    check("enp one wide", s_enable_p, 0);
    s_done_irq_p = 1; tick(); s_done_irq_p = 0;
    check("run2 done", s_done, 1);

    // Start from DONE clears done and re-runs
    s_start = 1; tick(); s_start = 0;
    check("done start enp", s_enable_p, 1);
    check("done start done", s_done, 0);
    check("done start busy", s_busy, 1);
    s_start = 1; tick(); s_start = 0;
    check("pre-rst err", s_err, 1);

    // Reset 10 cycles after enable_p, asynchronously mid-cycle
    for (int k = 0; k < 8; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", s_busy, 0);
    check("arst done", s_done, 0);
    check("arst err", s_err, 0);
    check("arst enable_p", s_enable_p, 0);
    check("arst m_size", s_m_size, 12'd2048);
    check("arst m", s_m, 0);
    tick();
    rst = 1'b0;
    tick();
    s_done_irq_p = 1; tick(); s_done_irq_p = 0;
    tick();
    check("post-rst irq done", s_done, 0);
    check("post-rst irq busy", s_busy, 0);

    // Full-size load and unload against a stub core
    for (int i = 0; i < 64; i++) begin
      w = (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
      bm[32*i +: 32] = w;
      be[32*i +: 32] = ~w;
      by[32*i +: 32] = 32'hA5000000 | 32'(i * 3);
    end
    bm[BNB-1] = 1'b1;
    bm[0]     = 1'b1;
    br = '0 - bm;
    for (int i = 0; i < 64; i++) begin
      b_wr_en = 1; b_wr_sel = 3'd0; b_wr_data = bm[32*i +: 32]; tick();
    end
    for (int i = 0; i < 64; i++) begin
      b_wr_sel = 3'd3; b_wr_data = br[32*i +: 32]; tick();
    end
    for (int i = 0; i < 64; i++) begin
      b_wr_sel = 3'd2; b_wr_data = be[32*i +: 32]; tick();
    end
    b_wr_en = 0;
    check("big m", b_m === bm, 1'b1);
    check("big r_red", b_r_red === br, 1'b1);
    check("big exp", b_exp === be, 1'b1);
    check("big a", b_a === '0, 1'b1);
    check("big err", b_err, 0);
    b_start = 1; tick(); b_start = 0;
    check("big enp", b_enable_p, 1);
    tick(); tick();
    b_y = by;
    b_done_irq_p = 1; tick(); b_done_irq_p = 0;
    check("big done", b_done, 1);
    b_rd_en = 1;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("big rd w%0d", i), b_rd_data, by[32*i +: 32]);
      tick();
    end
    b_rd_en = 0;
    check("big done after unload", b_done, 1);
    check("big busy after unload", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Word-serial host-side controller that drives the mod_exp core. It is the initiator that loads the core's wide operands, fires enable_p, waits for done_irq_p and unloads y.
- Sits between a 32-bit register/bus port and mod_exp.
- Turns WW-bit writes into NBITS-bit operand registers, and returns the NBITS-bit result as WW-bit reads with sticky done/error status.

Parameters:
- NBITS, 2048, operand/result width; must be a multiple of WW.
- WW, 32, host word width.
- NWORDS, NBITS/WW, words per operand (derived localparam).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_sel  in  3  target: 0=m, 1=a, 2=exp, 3=r_red, 4=m_size; 5-7 reserved
- wr_data  in  WW  write word
- start  in  1  host start request (level sampled each cycle)
- rd_en  in  1  host pop of one result word
- rd_data  out  WW  current result word
- irq_clr  in  1  clears done and err
- busy  out  1  operation in progress
- done  out  1  sticky result-ready flag
- err  out  1  sticky protocol-error flag
- enable_p  out  1  one-cycle start pulse to core
- a  out  NBITS  base to core
- exp  out  NBITS  exponent to core
- m  out  NBITS  modulus to core
- m_size  out  12  modulus bit length to core
- r_red  out  NBITS  2^m_size - m, host-supplied
- y  in  NBITS  core result
- done_irq_p  in  1  core completion pulse

Behaviour:
- Reset values:
  - a, exp, m, r_red = 0; m_size = 12'd2048.
  - enable_p, busy, done, err = 0; rd_data = 0; result register = 0; read counter = 0; state = IDLE.
- Operand load (sel 0-3) is a shift-in: reg <= {wr_data, reg[NBITS-1:WW]}.
  - After NWORDS writes, the first word written is bits [WW-1:0] (LSW first).
  - No write counter; extra writes keep shifting.
- m_size load (sel 4): m_size <= wr_data[11:0]. Reserved sel values: write ignored, err set.
- FSM states IDLE, RUN, DONE:
  - IDLE: writes accepted. start=1 -> RUN next cycle, enable_p=1 for exactly that one cycle, busy=1.
  - RUN: busy=1 and operands held stable. wr_en or start during RUN -> ignored, err set. done_irq_p=1 -> capture y into result register, read counter=0, done=1, busy=0, state DONE (all next cycle).
  - DONE: rd_data = result[WW-1:0] (registered output, valid the cycle done rises).
    - rd_en: result shifts right by WW, counter increments, rd_data shows the next word next cycle.
    - On the NWORDS-th rd_en -> IDLE. done stays 1 until irq_clr.
    - Writes accepted in DONE.
    - start in DONE behaves as in IDLE: enable_p pulse, RUN, done cleared.
- rd_en outside DONE: ignored, no error.
- irq_clr clears done and err next cycle. If a set event occurs in the same cycle, the set wins.
- Simultaneous wr_en and start in IDLE/DONE: the write takes effect in the same cycle. enable_p rises next cycle, so the core sees updated operands.
- done_irq_p while not in RUN: ignored.
- rst asserted mid-operation: all state returns to reset values immediately and asynchronously. A core result arriving later is ignored (state IDLE).
- enable_p never asserts on two consecutive cycles.

Test Plan:
- Load order (NBITS=64, WW=32): write m words 0x89ABCDEF then 0x01234567 -> m = 64'h0123456789ABCDEF. Write sel 4 = 0x040 -> m_size = 12'd64. Write sel 6 -> err=1, no register changes.
- Start handshake: start high 3 cycles in IDLE -> exactly one enable_p pulse, 1 cycle wide, on the cycle after the first start. busy=1 until done_irq_p. The extra start cycles while RUN set err.
- Result unload (stub core, NBITS=64): y = 64'hFEDCBA9876543210 with done_irq_p -> next cycle done=1, rd_data=32'h76543210. After 1 rd_en -> 32'hFEDCBA98. After 2nd rd_en -> state IDLE, done still 1. irq_clr -> done=0.
- Write during RUN: wr_sel=1, data 0xFFFFFFFF while busy -> a unchanged, err=1. irq_clr together with another illegal write -> err stays 1.
- Full-size run (NBITS=2048) with real mod_exp: load 64 words each of m, exp, r_red = 2^2048-m, a=0 -> after done, 64 reads reproduce the core's y. Compare against model.
- Reset mid-RUN: assert rst 10 cycles after enable_p -> busy, done, err, enable_p = 0 and m_size = 2048 immediately. A later done_irq_p produces no done.
